// File: rtl/e6_pwm_core.sv
// Counter/compare PWM generator with period-boundary double-buffered config,
// period-end pulse and sticky interrupt, fed by the E6_PWM register slave.
module e6_pwm_core #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               cfg_enable,
  input  logic               cfg_polarity,
  input  logic               cfg_irq_en,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_duty,
  input  logic [PRESC_W-1:0] cfg_prescale,
  input  logic               cfg_wr_strobe,
  input  logic               irq_clr,
  output logic               pwm_out,
  output logic               period_end,
  output logic               irq,
  output logic               update_pending,
  output logic [CNT_W-1:0]   cnt_value
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [PRESC_W-1:0] presc_cnt;
  logic [CNT_W-1:0]   period_sh;
  logic [CNT_W-1:0]   duty_sh;
  logic [PRESC_W-1:0] presc_sh;
  logic               pol_sh;

  logic run_active;
  logic tick;
  logic wrap;
  logic load_sh;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    tick       = 1'b0;
    wrap       = 1'b0;
    load_sh    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_enable) state_next = RUN;
      end
      RUN: begin
        if (!cfg_enable) begin
          state_next = IDLE;
        end else begin
          tick    = (presc_cnt == presc_sh);
          wrap    = tick && (cnt == period_sh);
          // A strobe landing on the wrap edge is picked up directly.
          load_sh = wrap && (update_pending || cfg_wr_strobe);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stop is immediate: the edge that sees cfg_enable low already behaves as IDLE.
  assign run_active = (state == RUN) && cfg_enable;

  // NOTE: sequential state uses non-blocking (<=) so all registers update together on the edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt            <= '0;
      presc_cnt      <= '0;
      period_sh      <= '0;
      duty_sh        <= '0;
      presc_sh       <= '0;
      pol_sh         <= 1'b0;
      pwm_out        <= 1'b0;
      period_end     <= 1'b0;
      update_pending <= 1'b0;
    end else if (!run_active) begin
      // Idle, or the stop edge: hold the counters cleared and let shadows follow the live config.
      cnt            <= '0;
      presc_cnt      <= '0;
      period_sh      <= cfg_period;
      duty_sh        <= cfg_duty;
      presc_sh       <= cfg_prescale;
      pol_sh         <= cfg_polarity;
      pwm_out        <= cfg_polarity;
      period_end     <= 1'b0;
      update_pending <= 1'b0;
    end else begin
      presc_cnt  <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
      period_end <= wrap;
      pwm_out    <= pol_sh ^ (cnt < duty_sh);
      if (load_sh) begin
        period_sh      <= cfg_period;
        duty_sh        <= cfg_duty;
        presc_sh       <= cfg_prescale;
        pol_sh         <= cfg_polarity;
        update_pending <= 1'b0;
      end else if (cfg_wr_strobe) begin
        update_pending <= 1'b1;
      end
    end
  end

  // Set has priority over a coincident clear; irq survives a stop.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                 irq <= 1'b0;
    else if (wrap && cfg_irq_en)  irq <= 1'b1;
    else if (irq_clr)             irq <= 1'b0;
  end

  assign cnt_value = cnt;

endmodule
